updi_txn_ctrl: RTL

Transaction sequencer that drives the UPDI physical layer (UART FIFOs plus double-break generator) on behalf of a single command requester. One command runs as follows: optional double break, SYNC (0x55), opcode, 0–4 payload bytes, echo check of every byte sent, then 0–4 response bytes. The result is returned as a single response pulse. The block sits between the instruction/NVM layer above and the PHY below, and is the only writer of the PHY TX FIFO and the only reader of its RX FIFO.

---
 rtl/updi_txn_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/updi_txn_ctrl.sv
// updi_txn_ctrl: runs one UPDI command at a time over the PHY FIFOs.
// Each command is an optional double break, SYNC, opcode, payload, echo check and response capture.
module updi_txn_ctrl #(
  parameter int TIMEOUT_CLK = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_break,
  input  logic [7:0]  cmd_opcode,
  input  logic [2:0]  cmd_tx_len,
  input  logic [31:0] cmd_tx_data,
  input  logic [2:0]  cmd_rx_len,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_error,
  output logic        busy,
  output logic [7:0]  phy_tx_data,
  output logic        phy_tx_wr_en,
  input  logic        phy_tx_full,
  input  logic [7:0]  phy_rx_data,
  output logic        phy_rx_rd_en,
  input  logic        phy_rx_empty,
  input  logic        phy_rx_error,
  output logic        db_start,
  input  logic        db_busy,
  input  logic        db_done
);
  localparam int CW = $clog2(TIMEOUT_CLK);
  typedef enum logic [2:0] {IDLE, BREAK, BREAK_WAIT, SEND, ECHO, RECV, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] k_q, k_d, tx_len_q, tx_len_d, rx_len_q, rx_len_d, last_k;
  logic [7:0] opcode_q, opcode_d, tx_byte;
  logic [31:0] tx_data_q, tx_data_d, rsp_data_q, rsp_data_d;
  logic [1:0] err_q, err_d, bsel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout, pop, unused_db_busy;
  assign unused_db_busy = db_busy;
  assign last_k = tx_len_q + 3'd1;
  // Payload bytes sit at k=2..5; wrapping k-2 in two bits selects byte 0..3.
  assign bsel = k_q[1:0] - 2'd2;
  assign tx_byte = k_q == 3'd0 ? 8'h55 : k_q == 3'd1 ? opcode_q : tx_data_q[{bsel, 3'b000} +: 8];
  assign timeout = cnt_q == CW'(TIMEOUT_CLK - 1);
  assign pop = (state_q == ECHO || state_q == RECV || state_q == DRAIN) && !phy_rx_empty;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign db_start = state_q == BREAK;
  assign rsp_valid = state_q == DONE;
  assign rsp_data = rsp_data_q;
  assign rsp_error = err_q;
  assign phy_tx_wr_en = state_q == SEND && !phy_tx_full;
  assign phy_tx_data = phy_tx_wr_en ? tx_byte : 8'h00;
  assign phy_rx_rd_en = pop;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    tx_len_d = tx_len_q;
    rx_len_d = rx_len_q;
    opcode_d = opcode_q;
    tx_data_d = tx_data_q;
    rsp_data_d = rsp_data_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        tx_len_d = cmd_tx_len > 3'd4 ? 3'd4 : cmd_tx_len;
        rx_len_d = cmd_rx_len > 3'd4 ? 3'd4 : cmd_rx_len;
        opcode_d = cmd_opcode;
        tx_data_d = cmd_tx_data;
        rsp_data_d = '0;
        err_d = '0;
        k_d = '0;
        state_d = cmd_break ? BREAK : SEND;
      end
      BREAK: state_d = BREAK_WAIT;
      BREAK_WAIT: state_d = db_done ? SEND : BREAK_WAIT;
      SEND: if (!phy_tx_full) begin
        k_d = k_q == last_k ? 3'd0 : k_q + 3'd1;
        cnt_d = '0;
        state_d = k_q == last_k ? ECHO : SEND;
      end
      ECHO, RECV: begin
        cnt_d = pop ? '0 : cnt_q + CW'(1);
        if (pop) k_d = k_q + 3'd1;
        if (pop && state_q == RECV) rsp_data_d[{k_q[1:0], 3'b000} +: 8] = phy_rx_data;
        // Checked in priority order: rx_error, echo mismatch, timeout.
        if (phy_rx_error) begin
          err_d = 2'd1;
          cnt_d = '0;
          state_d = DRAIN;
        end else if (pop && state_q == ECHO && phy_rx_data != tx_byte) begin
          err_d = 2'd2;
          cnt_d = '0;
          state_d = DRAIN;
        end else if (!pop && timeout) begin
          err_d = 2'd3;
          cnt_d = '0;
          state_d = DRAIN;
        end else if (pop && state_q == ECHO && k_q == last_k) begin
          k_d = '0;
          state_d = rx_len_q == 3'd0 ? DONE : RECV;
        end else if (pop && state_q == RECV && k_q == rx_len_q - 3'd1) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        cnt_d = pop || timeout ? '0 : cnt_q + CW'(1);
        state_d = !pop && timeout ? DONE : DRAIN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q <= '0;
      tx_len_q <= '0;
      rx_len_q <= '0;
      opcode_q <= '0;
      tx_data_q <= '0;
      rsp_data_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      tx_len_q <= tx_len_d;
      rx_len_q <= rx_len_d;
      opcode_q <= opcode_d;
      tx_data_q <= tx_data_d;
      rsp_data_q <= rsp_data_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
